// File: rtl/iterative_divider_pkg.sv
// -----------------------------------------------------------------------------
// iterative_divider_pkg
//   Shared definitions for the multi-cycle RISC-V M-extension divide unit:
//   - funct codes selecting DIV / DIVU / REM / REMU
//   - 2-bit FSM state encoding (IDLE, RUN, FIX, DONE)
//   - small decode helpers for the funct field
// -----------------------------------------------------------------------------
package iterative_divider_pkg;

  // funct[1] selects remainder (1) vs quotient (0);
  // funct[0] selects unsigned (1) vs signed (0).
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] f);
    return ~f[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] f);
    return f[1];
  endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
//   One combinational restoring-division iteration.
//   Ports:
//     rem_in       partial remainder entering this step (WORDSIZE bits)
//     dividend_bit next dividend bit shifted into the remainder
//     divisor_mag  divisor magnitude (unsigned)
//     rem_out      partial remainder after the trial subtraction
//     quo_bit      quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step #(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] rem_in,
  input  logic                dividend_bit,
  input  logic [WORDSIZE-1:0] divisor_mag,
  output logic [WORDSIZE-1:0] rem_out,
  output logic                quo_bit
);

  // The shifted remainder can exceed WORDSIZE bits when the divisor magnitude
  // is above 2^(WORDSIZE-1), so it is kept one bit wider.
  logic [WORDSIZE:0] shifted;
  logic [WORDSIZE:0] diff;
  logic              ge;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor_mag};
    // With shifted[W] clear both operands are below 2^W, so diff[W] is the
    // borrow. With shifted[W] set the shifted value always exceeds the divisor.
    ge      = shifted[WORDSIZE] | ~diff[WORDSIZE];
    quo_bit = ge;
    rem_out = ge ? diff[WORDSIZE-1:0] : shifted[WORDSIZE-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU. One quotient
//   bit per cycle; operands are converted to magnitudes on start and the sign
//   is restored in a dedicated FIX cycle.
//   Ports:
//     clk, reset  rising-edge clock, asynchronous active-high reset
//     start       request; only accepted in IDLE
//     funct       00=DIV 01=DIVU 10=REM 11=REMU
//     dividend    rs1, sampled with an accepted start
//     divisor     rs2, sampled with an accepted start
//     busy        high in RUN, FIX and DONE
//     done        one-cycle pulse in DONE; result valid
//     result      quotient or remainder, held until the next load
//   Handshake: start is a request qualified by ~busy; it is accepted only on
//   an edge where the unit is IDLE, and done is the single-cycle completion
//   strobe for that request. Requests while busy are dropped, not queued.
// -----------------------------------------------------------------------------
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          funct,
  input  logic [WORDSIZE-1:0] dividend,
  input  logic [WORDSIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result
);

  localparam int CW = $clog2(WORDSIZE + 1);
  localparam logic [CW-1:0]       CNT_INIT = CW'(WORDSIZE);
  localparam logic [CW-1:0]       CNT_LAST = CW'(1);
  localparam logic [WORDSIZE-1:0] MOST_NEG = {1'b1, {(WORDSIZE-1){1'b0}}};
  localparam logic [WORDSIZE-1:0] ALL_ONES = {WORDSIZE{1'b1}};

  div_state_e state_q, state_d;

  logic [CW-1:0]       cnt_q;
  logic [WORDSIZE-1:0] rem_q;
  logic [WORDSIZE-1:0] quo_q;
  logic [WORDSIZE-1:0] dvs_q;
  logic                rem_sel_q;
  logic                dvd_neg_q;
  logic                dvs_neg_q;
  logic [WORDSIZE-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Operand decode on the input buses (only meaningful when start is taken)
  // ---------------------------------------------------------------------------
  logic                in_signed;
  logic                in_dvd_neg;
  logic                in_dvs_neg;
  logic [WORDSIZE-1:0] in_dvd_mag;
  logic [WORDSIZE-1:0] in_dvs_mag;
  logic                in_div_zero;
  logic                in_overflow;
  logic                in_special;
  logic [WORDSIZE-1:0] in_special_result;

  always_comb begin
    in_signed   = op_is_signed(funct);
    in_dvd_neg  = in_signed & dividend[WORDSIZE-1];
    in_dvs_neg  = in_signed & divisor[WORDSIZE-1];
    // Negating the most negative value yields the same bit pattern, which is
    // exactly its magnitude when read as unsigned.
    in_dvd_mag  = in_dvd_neg ? -dividend : dividend;
    in_dvs_mag  = in_dvs_neg ? -divisor  : divisor;
    in_div_zero = (divisor == '0);
    in_overflow = in_signed & (dividend == MOST_NEG) & (divisor == ALL_ONES);
    in_special  = in_div_zero | in_overflow;

    in_special_result = '0;
    if (in_div_zero) begin
      in_special_result = op_is_rem(funct) ? dividend : ALL_ONES;
    end else if (in_overflow) begin
      in_special_result = op_is_rem(funct) ? '0 : dividend;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring iteration
  // ---------------------------------------------------------------------------
  logic [WORDSIZE-1:0] step_rem;
  logic                step_bit;

  divider_step #(
    .WORDSIZE (WORDSIZE)
  ) u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WORDSIZE-1]),
    .divisor_mag  (dvs_q),
    .rem_out      (step_rem),
    .quo_bit      (step_bit)
  );

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX. For unsigned ops both flags are clear.
  // ---------------------------------------------------------------------------
  logic [WORDSIZE-1:0] quo_fixed;
  logic [WORDSIZE-1:0] rem_fixed;
  logic [WORDSIZE-1:0] fixed_result;

  always_comb begin
    quo_fixed    = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    rem_fixed    = dvd_neg_q ? -rem_q : rem_q;
    fixed_result = rem_sel_q ? rem_fixed : quo_fixed;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = in_special ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_sel_q <= op_is_rem(funct);
            dvd_neg_q <= in_dvd_neg;
            dvs_neg_q <= in_dvs_neg;
            rem_q     <= '0;
            // The quotient register starts out holding the dividend; its MSB
            // feeds each step and the freed LSB receives the quotient bit.
            quo_q     <= in_dvd_mag;
            dvs_q     <= in_dvs_mag;
            cnt_q     <= CNT_INIT;
            if (in_special) begin
              result_q <= in_special_result;
            end
          end
        end
        ST_RUN: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WORDSIZE-2:0], step_bit};
          cnt_q <= cnt_q - CNT_LAST;
        end
        ST_FIX: begin
          result_q <= fixed_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//   Directed vectors for the iterative divider at WORDSIZE=64: ordinary
//   signed/unsigned ops, divide-by-zero, signed overflow, ignored mid-run
//   start, back-to-back starts and asynchronous reset during RUN.
// -----------------------------------------------------------------------------
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int W        = 64;
  localparam int LAT_FULL = W + 2;
  localparam int LAT_SPEC = 1;
  localparam int NO_INJ   = 0;

  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MNEG = 64'h8000_0000_0000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   funct;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  iterative_divider #(
    .WORDSIZE (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct    (funct),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_result;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge with the unit idle. Issues one op, then
  // watches each cycle for busy, result hold and done. Optionally fires a
  // second start (9/3 DIVU) at cycle inj, which must be ignored. Returns at
  // the falling edge of the IDLE cycle following done.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [1:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat,
                        input int inj);
    int lat      = 0;
    bit busy_bad = 1'b0;
    bit hold_bad = 1'b0;
    funct    = f;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    funct    = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (!busy) busy_bad = 1'b1;
      if (done) lat = k;
      else if (result !== last_result) hold_bad = 1'b1;
      if (inj > 0 && k == inj) begin
        start    = 1'b1;
        funct    = DIV_OP_DIVU;
        dividend = 64'd9;
        divisor  = 64'd3;
      end else if (inj > 0 && k == inj + 1) begin
        start = 1'b0;
      end
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " busy"}, W'(busy_bad), '0);
    check({tag, " hold"}, W'(hold_bad), '0);
    check({tag, " result"}, result, exp_res);
    last_result = exp_res;
    @(negedge clk);
    check({tag, " idle"}, W'({done, busy}), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit saw_done;
    reset    = 1'b1;
    start    = 1'b0;
    funct    = DIV_OP_DIV;
    dividend = '0;
    divisor  = '0;
    last_result = '0;
    repeat (2) @(negedge clk);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset result", result, '0);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned basics
    run_op("divu 100/7", DIV_OP_DIVU, 64'd100, 64'd7, 64'd14, LAT_FULL, NO_INJ);
    run_op("remu 100/7", DIV_OP_REMU, 64'd100, 64'd7, 64'd2,  LAT_FULL, NO_INJ);

    // Signed: -7/2, 7/-2, -100/-7
    run_op("div -7/2", DIV_OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL, NO_INJ);
    run_op("rem -7/2", DIV_OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           ONES, LAT_FULL, NO_INJ);
    run_op("div 7/-2", DIV_OP_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL, NO_INJ);
    run_op("rem 7/-2", DIV_OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'd1, LAT_FULL, NO_INJ);
    run_op("div -100/-7", DIV_OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
           64'd14, LAT_FULL, NO_INJ);
    run_op("rem -100/-7", DIV_OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
           64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL, NO_INJ);

    // Divide by zero
    run_op("divu 5/0", DIV_OP_DIVU, 64'd5, 64'd0, ONES,  LAT_SPEC, NO_INJ);
    run_op("rem 5/0",  DIV_OP_REM,  64'd5, 64'd0, 64'd5, LAT_SPEC, NO_INJ);

    // Signed overflow, and the same bit patterns as unsigned
    run_op("div ovf",  DIV_OP_DIV,  MNEG, ONES, MNEG,  LAT_SPEC, NO_INJ);
    run_op("rem ovf",  DIV_OP_REM,  MNEG, ONES, '0,    LAT_SPEC, NO_INJ);
    run_op("divu mn",  DIV_OP_DIVU, MNEG, ONES, '0,    LAT_FULL, NO_INJ);
    run_op("remu mn",  DIV_OP_REMU, MNEG, ONES, MNEG,  LAT_FULL, NO_INJ);

    // Start while busy is ignored; then back-to-back start right after done
    run_op("divu inj", DIV_OP_DIVU, 64'd100, 64'd7, 64'd14, LAT_FULL, 10);
    run_op("divu 9/3", DIV_OP_DIVU, 64'd9,   64'd3, 64'd3,  LAT_FULL, NO_INJ);

    // Asynchronous reset in the middle of RUN
    funct    = DIV_OP_DIVU;
    dividend = 64'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async rst busy", W'(busy), '0);
    check("async rst done", W'(done), '0);
    check("async rst result", result, '0);
    last_result = '0;
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("no done after rst", W'(saw_done), '0);
    run_op("divu 8/2", DIV_OP_DIVU, 64'd8, 64'd2, 64'd4, LAT_FULL, NO_INJ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
